// File: rtl/sa_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sa_ctrl_pkg                                                |
// | Description : Shared types and constants for the systolic-array job      |
// |               arbiter: FSM state encoding, operand/result matrices.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package sa_ctrl_pkg;

  // Number of requesters sharing the multiplier.
  localparam int N_REQ   = 2;
  // Matrix edge length (rows == columns).
  localparam int MAT_DIM = 4;

  // Row-major matrices: m[row][col], row 0 / col 0 in the least significant bits.
  typedef logic [MAT_DIM-1:0][MAT_DIM-1:0][7:0]  mat8_t;
  typedef logic [MAT_DIM-1:0][MAT_DIM-1:0][15:0] mat16_t;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Requester id to one-hot valid vector.
  function automatic logic [N_REQ-1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage : sa_ctrl_pkg
`default_nettype wire

// File: rtl/sa_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sa_rr_arb2                                                 |
// | Description : Two-way round-robin grant. The pointer names the favoured  |
// |               requester; it wins a tie, otherwise the sole requester     |
// |               wins. Purely combinational, grant is one-hot or zero.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sa_rr_arb2
  import sa_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] i_valid,
  input  logic             i_ptr,
  output logic [N_REQ-1:0] o_grant
);

  logic w_other;

  assign w_other = ~i_ptr;

  // Favoured requester first, then the other one.
  always_comb begin
    o_grant = '0;
    if (i_valid[i_ptr]) begin
      o_grant[i_ptr] = 1'b1;
    end else if (i_valid[w_other]) begin
      o_grant[w_other] = 1'b1;
    end
  end

endmodule : sa_rr_arb2
`default_nettype wire

// File: rtl/sa_job_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sa_job_arbiter                                             |
// | Description : Shares one 4x4 matrix multiplier between two requesters.   |
// |               Round-robin accept, single-cycle launch, capture of the    |
// |               first result strobe while waiting, then a held response    |
// |               to the granted requester until it is consumed.             |
// |               Optional watchdog abort enabled by the macro               |
// |               SA_JOB_ARBITER_TIMEOUT_EN.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sa_job_arbiter
  import sa_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
)
(
  input  logic               i_clk,
  input  logic               i_arst,
  // requester side
  input  logic   [N_REQ-1:0] i_req_valid,
  output logic   [N_REQ-1:0] o_req_ready,
  input  mat8_t  [N_REQ-1:0] i_req_a,
  input  mat8_t  [N_REQ-1:0] i_req_b,
  output logic   [N_REQ-1:0] o_resp_valid,
  input  logic   [N_REQ-1:0] i_resp_ready,
  output mat16_t             o_resp_c,
  output logic               o_resp_err,
  // multiplier side
  output mat8_t              o_mm_a,
  output mat8_t              o_mm_b,
  output logic               o_mm_valid_input,
  input  mat16_t             i_mm_c,
  input  logic               i_mm_valid_result,
  // status
  output logic               o_busy
);

  // Reject out-of-range watchdog settings at elaboration.
  generate
    if (TIMEOUT_CYCLES < 12 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("sa_job_arbiter: TIMEOUT_CYCLES must be within 12..255");
    end
  endgenerate

  state_t            r_state;
  logic              r_ptr;
  logic              r_id;
  logic  [N_REQ-1:0] r_resp_valid;
  mat16_t            r_resp_c;
  mat8_t             r_mm_a;
  mat8_t             r_mm_b;
  logic              r_mm_valid;
  logic              r_busy;

  logic  [N_REQ-1:0] w_grant;
  logic              w_idle;
  logic              w_accept;
  logic              w_gid;
  logic              w_wd_expire;

  sa_rr_arb2 u_rr_arb2 (
    .i_valid (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && (w_grant != '0);
  // Grant is one-hot, so the upper bit is the granted id.
  assign w_gid    = w_grant[1];

  // Ready is only offered in IDLE, so a request can never be taken on the
  // same cycle as a response handshake.
  assign o_req_ready      = w_idle ? w_grant : '0;
  assign o_resp_valid     = r_resp_valid;
  assign o_resp_c         = r_resp_c;
  assign o_mm_a           = r_mm_a;
  assign o_mm_b           = r_mm_b;
  assign o_mm_valid_input = r_mm_valid;
  assign o_busy           = r_busy;

`ifdef SA_JOB_ARBITER_TIMEOUT_EN
  localparam logic [7:0] c_wd_last = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wd_cnt;
  logic       r_resp_err;

  // Count consecutive WAIT cycles; cleared in every other state.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wd_cnt <= r_wd_cnt + 8'd1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // The last permitted WAIT cycle; a strobe in that same cycle still wins.
  assign w_wd_expire = (r_wd_cnt == c_wd_last);
  assign o_resp_err  = r_resp_err;
`else
  assign w_wd_expire = 1'b0;
  assign o_resp_err  = 1'b0;
`endif

  // Job sequencing FSM with registered outputs.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= 1'b0;
      r_id         <= 1'b0;
      r_resp_valid <= '0;
      r_resp_c     <= '0;
      r_mm_a       <= '0;
      r_mm_b       <= '0;
      r_mm_valid   <= 1'b0;
      r_busy       <= 1'b0;
`ifdef SA_JOB_ARBITER_TIMEOUT_EN
      r_resp_err   <= 1'b0;
`endif
    end else begin
      // Launch is a one-cycle pulse unless re-armed below.
      r_mm_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id       <= w_gid;
            r_ptr      <= ~w_gid;
            r_mm_a     <= i_req_a[w_gid];
            r_mm_b     <= i_req_b[w_gid];
            r_mm_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // Result strobes here are stale wrap-around pulses; ignore them.
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_mm_valid_result) begin
            r_resp_c     <= i_mm_c;
            r_resp_valid <= id_to_onehot(r_id);
            r_state      <= ST_RESP;
`ifdef SA_JOB_ARBITER_TIMEOUT_EN
            r_resp_err   <= 1'b0;
`endif
          end else if (w_wd_expire) begin
            r_resp_c     <= '0;
            r_resp_valid <= id_to_onehot(r_id);
            r_state      <= ST_RESP;
`ifdef SA_JOB_ARBITER_TIMEOUT_EN
            r_resp_err   <= 1'b1;
`endif
          end
        end
        ST_RESP: begin
          // Only the owner of the job may consume the result.
          if (i_resp_ready[r_id]) begin
            r_resp_valid <= '0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_resp_valid <= '0;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : sa_job_arbiter
`default_nettype wire

// File: tb/tb_sa_job_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sa_job_arbiter                                          |
// | Description : Self-checking bench for sa_job_arbiter with a behavioural  |
// |               multiplier (result 11 cycles after launch) and a           |
// |               round-robin / matrix-product reference model.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sa_job_arbiter;
  import sa_ctrl_pkg::*;

  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              arst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  mat8_t [1:0]       req_a;
  mat8_t [1:0]       req_b;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  mat16_t            resp_c;
  logic              resp_err;
  mat8_t             mm_a;
  mat8_t             mm_b;
  logic              mm_vi;
  mat16_t            mm_c = '0;
  logic              mm_vr = 1'b0;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  int rr_ptr = 0;

  // multiplier model controls
  int    mm_cnt = 0;
  bit    mm_mute = 1'b0;
  bit    spur_idle = 1'b0;
  bit    spur_launch = 1'b0;
  mat8_t mm_a_q, mm_b_q;

  always #5 clk = ~clk;

  sa_job_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk             (clk),
    .i_arst            (arst),
    .i_req_valid       (req_valid),
    .o_req_ready       (req_ready),
    .i_req_a           (req_a),
    .i_req_b           (req_b),
    .o_resp_valid      (resp_valid),
    .i_resp_ready      (resp_ready),
    .o_resp_c          (resp_c),
    .o_resp_err        (resp_err),
    .o_mm_a            (mm_a),
    .o_mm_b            (mm_b),
    .o_mm_valid_input  (mm_vi),
    .i_mm_c            (mm_c),
    .i_mm_valid_result (mm_vr),
    .o_busy            (busy)
  );

  function automatic mat16_t matmul(input mat8_t a, input mat8_t b);
    mat16_t c;
    int s;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        s = 0;
        for (int j = 0; j < 4; j++) s += int'(a[r][j]) * int'(b[j][k]);
        c[r][k] = 16'(s);
      end
    end
    return c;
  endfunction

  function automatic mat8_t rand_mat();
    mat8_t m;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) m[r][k] = 8'($urandom);
    return m;
  endfunction

  function automatic mat8_t fill_mat(input logic [7:0] v);
    mat8_t m;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) m[r][k] = v;
    return m;
  endfunction

  // Reference round-robin: favoured requester wins a tie.
  function automatic int exp_winner(input logic [1:0] v);
    if (v[rr_ptr]) return rr_ptr;
    return 1 - rr_ptr;
  endfunction

  // Behavioural multiplier: result strobe 11 cycles after the launch cycle,
  // optional spurious strobes carrying garbage data.
  always @(negedge clk) begin
    mm_vr = 1'b0;
    mm_c  = {16{16'hDEAD}};
    if (mm_cnt > 0) begin
      mm_cnt--;
      if (mm_cnt == 0 && !mm_mute) begin
        mm_vr = 1'b1;
        mm_c  = matmul(mm_a_q, mm_b_q);
      end
    end
    if (mm_vi) begin
      mm_cnt = 11;
      mm_a_q = mm_a;
      mm_b_q = mm_b;
      if (spur_launch) begin
        mm_vr       = 1'b1;
        spur_launch = 1'b0;
      end
    end else if (spur_idle && !busy) begin
      mm_vr     = 1'b1;
      spur_idle = 1'b0;
    end
  end

  // Wait (bounded) for a ready; called just after a negedge.
  task automatic wait_accept(output logic [1:0] rdy, output int waited);
    rdy = '0;
    waited = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        rdy = req_ready;
        break;
      end
      @(negedge clk);
      waited++;
    end
  endtask

  // From the accept cycle, count cycles until a response appears.
  task automatic wait_resp(input logic [1:0] drop, input bit scramble, output int lat,
                           output bit p1, output bit p2, output mat8_t a1, output mat8_t b1);
    lat = 0;
    p1 = 1'b0;
    p2 = 1'b0;
    a1 = '0;
    b1 = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid = req_valid & ~drop;
        p1 = mm_vi;
        a1 = mm_a;
        b1 = mm_b;
        if (scramble) begin
          req_a[0] = rand_mat(); req_b[0] = rand_mat();
          req_a[1] = rand_mat(); req_b[1] = rand_mat();
        end
      end
      if (lat == 2) p2 = mm_vi;
    end while (resp_valid == 2'b00 && lat < 400);
  endtask

  task automatic do_reset();
    req_valid  = '0;
    resp_ready = '0;
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    rr_ptr = 0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    req_valid = '0; resp_ready = '0;
    req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, resp_err, mm_vi, busy} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 0", {req_ready, resp_valid, resp_err, mm_vi, busy});
    end
    n_vec++;
    if (resp_c !== '0) begin n_err++; $display("FAIL reset_resp_c: got %h want 0", resp_c); end
    n_vec++;
    if ({mm_a, mm_b} !== '0) begin n_err++; $display("FAIL reset_mm_ab: got %h want 0", {mm_a, mm_b}); end
    arst = 1'b0;
    rr_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    mat8_t a, b, a1, b1;
    mat16_t ec;
    logic [1:0] rdy;
    int w, lat;
    bit p1, p2;
    a = '0;
    for (int i = 0; i < 4; i++) a[i][i] = 8'd1;
    b = fill_mat(8'd2);
    ec = matmul(a, b);
    req_a[0] = a; req_b[0] = b; req_valid = 2'b01;
    wait_accept(rdy, w);
    n_vec++;
    if (rdy !== 2'b01) begin n_err++; $display("FAIL basic_grant: got %b want 01", rdy); end
    rr_ptr = 1 - exp_winner(2'b01);
    wait_resp(2'b01, 1'b0, lat, p1, p2, a1, b1);
    n_vec++;
    if (lat !== 13) begin n_err++; $display("FAIL basic_latency: got %0d want 13", lat); end
    n_vec++;
    if ({p1, p2} !== 2'b10) begin n_err++; $display("FAIL basic_launch_pulse: got %b want 10", {p1, p2}); end
    n_vec++;
    if ({a1, b1} !== {a, b}) begin n_err++; $display("FAIL basic_mm_ops: got %h want %h", {a1, b1}, {a, b}); end
    n_vec++;
    if ({resp_valid, resp_err, busy} !== 4'b0101) begin
      n_err++; $display("FAIL basic_resp_flags: got %b want 0101", {resp_valid, resp_err, busy});
    end
    n_vec++;
    if (resp_c !== ec) begin n_err++; $display("FAIL basic_resp_c: got %h want %h", resp_c, ec); end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;
    n_vec++;
    if ({resp_valid, busy} !== 3'b000) begin n_err++; $display("FAIL basic_release: got %b want 000", {resp_valid, busy}); end
  endtask

  task automatic test_simultaneous();
    mat8_t a0, b0, a1, b1;
    logic [1:0] rdy;
    int w, lat;
    bit p1, p2;
    do_reset();
    a0 = rand_mat(); b0 = rand_mat();
    req_a[0] = a0; req_b[0] = b0;
    req_a[1] = fill_mat(8'd1); req_b[1] = fill_mat(8'd3);
    req_valid = 2'b11;
    wait_accept(rdy, w);
    n_vec++;
    if (rdy !== 2'b01) begin n_err++; $display("FAIL simul_first_grant: got %b want 01", rdy); end
    rr_ptr = 1 - exp_winner(2'b11);
    wait_resp(2'b01, 1'b0, lat, p1, p2, a1, b1);
    n_vec++;
    if (resp_valid !== 2'b01 || resp_c !== matmul(a0, b0)) begin
      n_err++; $display("FAIL simul_port0_resp: got %b %h want 01 %h", resp_valid, resp_c, matmul(a0, b0));
    end
    resp_ready = 2'b01;
    #1;
    n_vec++;
    if (req_ready !== 2'b00) begin n_err++; $display("FAIL simul_no_accept_in_handshake: got %b want 00", req_ready); end
    @(negedge clk);
    resp_ready = 2'b00;
    wait_accept(rdy, w);
    n_vec++;
    if (rdy !== 2'b10 || w !== 0) begin n_err++; $display("FAIL simul_second_grant: got %b/%0d want 10/0", rdy, w); end
    rr_ptr = 1 - exp_winner(2'b10);
    wait_resp(2'b10, 1'b0, lat, p1, p2, a1, b1);
    n_vec++;
    if (lat !== 13 || resp_valid !== 2'b10) begin
      n_err++; $display("FAIL simul_port1_timing: got %0d %b want 13 10", lat, resp_valid);
    end
    n_vec++;
    if (resp_c !== {16{16'd12}}) begin n_err++; $display("FAIL simul_port1_c: got %h want all 12", resp_c); end
    resp_ready = 2'b10;
    @(negedge clk);
    resp_ready = 2'b00;
  endtask

  task automatic test_hold();
    mat8_t a, b, a1, b1;
    mat16_t ec;
    logic [1:0] rdy;
    int w, lat;
    bit p1, p2;
    a = rand_mat(); b = rand_mat(); ec = matmul(a, b);
    req_a[1] = a; req_b[1] = b; req_valid = 2'b10;
    wait_accept(rdy, w);
    n_vec++;
    if (rdy !== 2'b10) begin n_err++; $display("FAIL hold_grant: got %b want 10", rdy); end
    rr_ptr = 1 - exp_winner(2'b10);
    wait_resp(2'b10, 1'b0, lat, p1, p2, a1, b1);
    // Competing request and the wrong consumer pulling ready while we hold.
    req_a[0] = rand_mat(); req_valid = 2'b01; resp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (resp_valid !== 2'b10 || resp_c !== ec) begin
        n_err++; $display("FAIL hold_stable[%0d]: got %b %h want 10 %h", i, resp_valid, resp_c, ec);
      end
      n_vec++;
      if (req_ready !== 2'b00) begin n_err++; $display("FAIL hold_no_accept[%0d]: got %b want 00", i, req_ready); end
      @(negedge clk);
    end
    req_valid = 2'b00;
    resp_ready = 2'b10;
    @(negedge clk);
    resp_ready = 2'b00;
    n_vec++;
    if (resp_valid !== 2'b00) begin n_err++; $display("FAIL hold_release: got %b want 00", resp_valid); end
  endtask

  task automatic test_spurious();
    mat8_t a, b, a1, b1;
    mat16_t c_before;
    logic [1:0] rdy;
    int w, lat;
    bit p1, p2;
    c_before = resp_c;
    spur_idle = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({resp_valid, busy} !== 3'b000 || resp_c !== c_before) begin
      n_err++; $display("FAIL spur_idle: got %b %h want 000 %h", {resp_valid, busy}, resp_c, c_before);
    end
    a = rand_mat(); b = rand_mat();
    spur_launch = 1'b1;
    req_a[0] = a; req_b[0] = b; req_valid = 2'b01;
    wait_accept(rdy, w);
    rr_ptr = 1 - exp_winner(2'b01);
    wait_resp(2'b01, 1'b0, lat, p1, p2, a1, b1);
    n_vec++;
    if (lat !== 13) begin n_err++; $display("FAIL spur_launch_latency: got %0d want 13", lat); end
    n_vec++;
    if (resp_c !== matmul(a, b)) begin n_err++; $display("FAIL spur_launch_c: got %h want %h", resp_c, matmul(a, b)); end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = 2'b00;
  endtask

  task automatic test_timeout();
    mat8_t a1, b1;
    logic [1:0] rdy;
    int w, lat;
    bit p1, p2;
    mm_mute = 1'b1;
    req_a[1] = rand_mat(); req_b[1] = rand_mat(); req_valid = 2'b10;
    wait_accept(rdy, w);
    rr_ptr = 1 - exp_winner(2'b10);
`ifdef SA_JOB_ARBITER_TIMEOUT_EN
    // WAIT entry is accept+2; abort response follows TO WAIT cycles later.
    wait_resp(2'b10, 1'b0, lat, p1, p2, a1, b1);
    n_vec++;
    if (lat !== TO + 2) begin n_err++; $display("FAIL timeout_latency: got %0d want %0d", lat, TO + 2); end
    n_vec++;
    if ({resp_valid, resp_err} !== 3'b101 || resp_c !== '0) begin
      n_err++; $display("FAIL timeout_resp: got %b %h want 101 0", {resp_valid, resp_err}, resp_c);
    end
    resp_ready = 2'b10;
    @(negedge clk);
    resp_ready = 2'b00;
    mm_mute = 1'b0;
`else
    @(negedge clk);
    req_valid = 2'b00;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) lat++;
    end
    n_vec++;
    if (lat !== 0 || busy !== 1'b1 || resp_err !== 1'b0) begin
      n_err++; $display("FAIL no_watchdog_wait: got %0d %b %b want 0 1 0", lat, busy, resp_err);
    end
    mm_mute = 1'b0;
    do_reset();
`endif
  endtask

  task automatic test_reset_midjob();
    mat8_t a, b, a1, b1;
    logic [1:0] rdy;
    int w, lat, seen;
    bit p1, p2;
    req_a[0] = rand_mat(); req_b[0] = rand_mat(); req_valid = 2'b01;
    wait_accept(rdy, w);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #2 arst = 1'b1;
    #1;
    n_vec++;
    if ({req_ready, resp_valid, resp_err, mm_vi, busy} !== 7'b0 || resp_c !== '0 || {mm_a, mm_b} !== '0) begin
      n_err++; $display("FAIL midjob_reset_outputs: got %b %h %h want 0", {req_ready, resp_valid, resp_err, mm_vi, busy}, resp_c, {mm_a, mm_b});
    end
    @(negedge clk);
    arst = 1'b0;
    rr_ptr = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid != 2'b00 || busy) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL midjob_no_stale_resp: got %0d want 0", seen); end
    a = rand_mat(); b = rand_mat();
    req_a[1] = a; req_b[1] = b; req_valid = 2'b10;
    wait_accept(rdy, w);
    rr_ptr = 1 - exp_winner(2'b10);
    wait_resp(2'b10, 1'b0, lat, p1, p2, a1, b1);
    n_vec++;
    if (lat !== 13 || resp_valid !== 2'b10 || resp_c !== matmul(a, b)) begin
      n_err++; $display("FAIL midjob_recovery: got %0d %b %h want 13 10 %h", lat, resp_valid, resp_c, matmul(a, b));
    end
    resp_ready = 2'b10;
    @(negedge clk);
    resp_ready = 2'b00;
  endtask

  task automatic test_random();
    mat8_t ea, eb, a1, b1;
    logic [1:0] v, rdy, eg;
    int w, lat, win, dly;
    bit p1, p2;
    for (int it = 0; it < 24; it++) begin
      req_a[0] = rand_mat(); req_b[0] = rand_mat();
      req_a[1] = rand_mat(); req_b[1] = rand_mat();
      v = 2'($urandom_range(1, 3));
      win = exp_winner(v);
      eg = (win == 1) ? 2'b10 : 2'b01;
      ea = req_a[win]; eb = req_b[win];
      req_valid = v;
      wait_accept(rdy, w);
      n_vec++;
      if (rdy !== eg) begin n_err++; $display("FAIL rand_grant[%0d]: got %b want %b", it, rdy, eg); end
      rr_ptr = 1 - win;
      wait_resp(2'b11, 1'b1, lat, p1, p2, a1, b1);
      n_vec++;
      if (lat !== 13 || resp_valid !== eg || resp_err !== 1'b0) begin
        n_err++; $display("FAIL rand_resp[%0d]: got %0d %b %b want 13 %b 0", it, lat, resp_valid, resp_err, eg);
      end
      n_vec++;
      if (resp_c !== matmul(ea, eb)) begin
        n_err++; $display("FAIL rand_c[%0d]: got %h want %h", it, resp_c, matmul(ea, eb));
      end
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin
        resp_ready = ~eg & 2'($urandom);
        @(negedge clk);
      end
      n_vec++;
      if (resp_valid !== eg) begin n_err++; $display("FAIL rand_hold[%0d]: got %b want %b", it, resp_valid, eg); end
      resp_ready = eg;
      @(negedge clk);
      resp_ready = 2'b00;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_hold();
    test_spurious();
    test_timeout();
    test_reset_midjob();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sa_job_arbiter
`default_nettype wire
